// File: rtl/digit_counter_ctrl_if.sv
// Control/status bundle between a digit counter and its driver.
// The master drives controls; the slave (counter) drives digit/tick/carry.
interface digit_counter_ctrl_if;
  logic       run;
  logic       dir;
  logic       step_btn;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] digit;
  logic       tick;
  logic       carry;

  modport master (
    output run, dir, step_btn, load, load_value,
    input  digit, tick, carry
  );

  modport slave (
    input  run, dir, step_btn, load, load_value,
    output digit, tick, carry
  );
endinterface

// File: rtl/digit_counter_ctrl.sv
// Modulo-(MAX_DIGIT+1) up/down BCD digit with prescaled tick,
// debounced step button, synchronous load and carry/borrow out.
module digit_counter_ctrl #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGIT       = 5
) (
  input logic                 clk,
  input logic                 rst,
  digit_counter_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0]    DMAX     = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  logic          s1_q, s2_q;
  db_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    digit_q, digit_d;
  logic          carry_q, carry_d;
  logic          tick_q;
  logic          step_pulse;
  logic          tick_evt;
  logic          adv;
  logic          btn_s;

  assign btn_s    = s2_q;
  assign tick_evt = bus.run && (pre_q == PRE_LAST);
  assign adv      = tick_evt || step_pulse;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    step_pulse = 1'b0;
    case (st_q)
      IDLE: begin
        if (btn_s) begin
          st_d  = PRESS_WAIT;
          cnt_d = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == DB_MAX) begin
          st_d       = PRESSED;
          cnt_d      = '0;
          step_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          st_d  = RELEASE_WAIT;
          cnt_d = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high re-enters PRESSED silently
        if (btn_s) begin
          st_d  = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == DB_MAX) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pre_d = pre_q;
    if (bus.run) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_comb begin
    digit_d = digit_q;
    carry_d = 1'b0;
    if (bus.load) begin
      digit_d = (bus.load_value > DMAX) ? DMAX : bus.load_value;
    end else if (adv && !bus.dir) begin
      digit_d = (digit_q == DMAX) ? 4'd0 : digit_q + 4'd1;
      carry_d = (digit_q == DMAX);
    end else if (adv) begin
      digit_d = (digit_q == 4'd0) ? DMAX : digit_q - 4'd1;
      carry_d = (digit_q == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      st_q    <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      digit_q <= 4'd0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= bus.step_btn;
      s2_q    <= s1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
      tick_q  <= tick_evt;
    end
  end

  assign bus.digit = digit_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;

endmodule

// File: doc/digit_counter_ctrl.md
Name: digit_counter_ctrl

Overview:
Sequential source for the 4-bit BCD digit consumed by the seven-segment decoder in the seven_seg_counter design.
- Runs a modulo-(MAX_DIGIT+1) up/down counter, 0..5 by default.
- The counter advances on a prescaled timebase tick or on a debounced manual step button.
- Supports synchronous load.
- Emits carry/borrow for chaining to a higher digit stage.

Parameters:
- TICK_DIV, 50000000: clk cycles per timebase tick (1 Hz at 50 MHz); legal range is 2 or more.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a button level change; legal range is 1 or more.
- MAX_DIGIT, 5: highest digit value; legal range is 1..9.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- run, input, 1: level; 1 enables the timebase prescaler, 0 holds it.
- dir, input, 1: 0 counts up, 1 counts down.
- step_btn, input, 1: raw asynchronous pushbutton, active-high.
- load, input, 1: synchronous load strobe.
- load_value, input, 4: value to load.
- digit, output, 4: current digit; always in 0..MAX_DIGIT; drives the decoder's binary_input.
- tick, output, 1: one-cycle pulse marking a timebase tick.
- carry, output, 1: one-cycle pulse on wrap (up: MAX_DIGIT->0; down: 0->MAX_DIGIT).

Behaviour:
- Clocking and reset: one clock domain.
- On any edge with rst=1:
  - digit=0, tick=0, carry=0.
  - Prescaler=0.
  - Synchronizer flops=0.
  - Debounce FSM goes to IDLE and its counter clears.
  - A reset that arrives mid-debounce or mid-prescale discards the partial count.
- Synchronizer:
  - step_btn passes through 2 flops to give btn_s.
  - No other logic samples step_btn directly.
- Debounce FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: btn_s=1 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: btn_s=0 -> IDLE, counter cleared. Otherwise the counter increments. When the counter reaches DEBOUNCE_CYCLES with btn_s still 1 -> PRESSED, and step_pulse=1 for exactly that one cycle.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: btn_s=1 -> PRESSED, counter cleared, no new pulse. Otherwise the counter reaches DEBOUNCE_CYCLES -> IDLE.
  - Result: one step per press, however long the press is held.
- Prescaler:
  - When run=1, counts 0..TICK_DIV-1 and wraps to 0.
  - When run=0, holds its value without clearing, so resuming continues the partial period.
  - tick_evt = run & (prescaler==TICK_DIV-1).
- Advance event: adv = tick_evt | step_pulse. If both occur in the same cycle, the counter advances once only.
- Digit update, one registered edge, with priority load > adv:
  - load=1: digit <= min(load_value, MAX_DIGIT). carry <= 0. Any coincident adv is dropped, but the prescaler still wraps and tick is still asserted.
  - adv with dir=0: digit <= (digit==MAX_DIGIT) ? 0 : digit+1. carry <= (digit==MAX_DIGIT).
  - adv with dir=1: digit <= (digit==0) ? MAX_DIGIT : digit-1. carry <= (digit==0).
  - Neither load nor adv: digit holds, carry <= 0.
- Timing of outputs:
  - tick is registered: tick <= tick_evt.
  - New digit, tick and carry all become visible in the same cycle, one cycle after the prescaler reaches TICK_DIV-1.
  - carry and tick are never high for more than one consecutive cycle unless TICK_DIV=2 or loads interleave.
- A dir change takes effect on the next adv; no state is reset.
- Latency from step_btn rising to digit change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Test Plan:
1. Reset: assert rst for 2 cycles with the inputs toggling -> digit=0, tick=0, carry=0. With run=1 and TICK_DIV=4, the first tick arrives 4 cycles after rst drops.
2. Up-count wrap, TICK_DIV=4, run=1, dir=0:
   - digit steps 0,1,2,3,4,5,0, one step every 4 cycles.
   - tick pulses once per step.
   - carry=1 only in the cycle where digit becomes 0; it is 0 elsewhere.
3. Down-count from 0, dir=1:
   - 0 -> 5 with carry=1.
   - Then 4,3 with carry=0.
   - run=0 for 10 cycles: digit and prescaler hold. On resume the next tick comes after the remaining partial period.
4. Debounce, DEBOUNCE_CYCLES=3, run=0:
   - 1-cycle and 2-cycle glitches on step_btn -> no change.
   - A clean 20-cycle press -> exactly one +1, appearing 6 cycles after the press.
   - A bounce during release followed by a re-press after 3 stable low cycles -> second +1.
5. Simultaneous events:
   - tick_evt and step_pulse in the same cycle -> digit advances by exactly 1.
   - load=1 with load_value=3 in the same cycle as a tick -> digit=3, tick=1, carry=0.
6. Load clamp: load_value=9 -> digit=5. load_value=0 at digit=5 with dir=0 -> digit=0, carry=0.
